// File: rtl/pwm_div_multi.sv
// pwm_div_multi: multi-channel programmable clock divider / PWM generator.
// One shared period counter drives CH outputs. Each output has its own
// CNT_W-bit duty threshold. Period and duty values are written into shadow
// registers. They move to the active set only at a period boundary, or
// at any time while the block is disabled, so that outputs never glitch.
//
// Optional feature: define PWM_CENTER_EN to get center-aligned (up/down)
// counting. The mode is selected at run time by cfg_center, which is
// captured with the shadow values.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous reset, active low
//   en          1 = run; 0 = counter held at 0 and outputs low
//   cfg_wr      one-cycle strobe that captures cfg_period/cfg_duty/cfg_center
//   cfg_period  terminal count P; the edge-aligned period is P+1 cycles
//   cfg_duty    duty for channel i at bits [i*CNT_W +: CNT_W]
//   cfg_center  center-aligned request (used only with PWM_CENTER_EN)
//   cfg_pend    the shadow holds values that are not yet applied
//   tc          registered one-cycle pulse, once per period
//   pwm         registered PWM outputs
module pwm_div_multi #(
    parameter int CNT_W      = 8,
    parameter int CH         = 4,
    parameter int DEF_PERIOD = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  cfg_wr,
    input  logic [CNT_W-1:0]      cfg_period,
    input  logic [CH*CNT_W-1:0]   cfg_duty,
    input  logic                  cfg_center,
    output logic                  cfg_pend,
    output logic                  tc,
    output logic [CH-1:0]         pwm
);

    localparam logic [CNT_W-1:0] DEF_P = CNT_W'(DEF_PERIOD);

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    per_act_q, per_act_d;
    logic [CNT_W-1:0]    per_sh_q, per_sh_d;
    logic [CH*CNT_W-1:0] duty_act_q, duty_act_d;
    logic [CH*CNT_W-1:0] duty_sh_q, duty_sh_d;
    logic                pend_q, pend_d;
    logic                tc_q, tc_d;
    logic [CH-1:0]       pwm_q, pwm_d;
    logic                terminal;
    logic                xfer;

`ifdef PWM_CENTER_EN
    logic mode_act_q, mode_act_d;
    logic mode_sh_q, mode_sh_d;
    logic dir_down_q, dir_down_d;
    logic center_act;
`else
    logic center_unused;
    assign center_unused = cfg_center;
`endif

    always_comb begin
        per_act_d  = per_act_q;
        per_sh_d   = per_sh_q;
        duty_act_d = duty_act_q;
        duty_sh_d  = duty_sh_q;
        pend_d     = pend_q;
        cnt_d      = '0;
`ifdef PWM_CENTER_EN
        mode_act_d = mode_act_q;
        mode_sh_d  = mode_sh_q;
        dir_down_d = 1'b0;
        // P_act=0 has no up/down range, so it falls back to edge counting.
        center_act = mode_act_q && (per_act_q != '0);
        terminal   = center_act ? (dir_down_q && (cnt_q == '0))
                                : (cnt_q == per_act_q);
`else
        terminal   = (cnt_q == per_act_q);
`endif
        // While disabled, shadow values pass through to the active set every cycle.
        xfer = en ? terminal : 1'b1;

        if (xfer) begin
            if (cfg_wr) begin
                per_act_d  = cfg_period;
                duty_act_d = cfg_duty;
                per_sh_d   = cfg_period;
                duty_sh_d  = cfg_duty;
`ifdef PWM_CENTER_EN
                mode_act_d = cfg_center;
                mode_sh_d  = cfg_center;
`endif
            end else begin
                per_act_d  = per_sh_q;
                duty_act_d = duty_sh_q;
`ifdef PWM_CENTER_EN
                mode_act_d = mode_sh_q;
`endif
            end
            pend_d = 1'b0;
        end else if (cfg_wr) begin
            per_sh_d  = cfg_period;
            duty_sh_d = cfg_duty;
`ifdef PWM_CENTER_EN
            mode_sh_d = cfg_center;
`endif
            pend_d    = 1'b1;
        end

        if (en) begin
`ifdef PWM_CENTER_EN
            if (center_act) begin
                if (terminal) begin
                    // Count 0 was already spent on the way down. Restart at 1
                    // only while the next period is center-aligned as well.
                    cnt_d = (mode_act_d && (per_act_d != '0)) ? CNT_W'(1) : '0;
                end else if (!dir_down_q && (cnt_q == per_act_q)) begin
                    cnt_d      = cnt_q - 1'b1;
                    dir_down_d = 1'b1;
                end else if (dir_down_q) begin
                    cnt_d      = cnt_q - 1'b1;
                    dir_down_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                cnt_d = terminal ? '0 : cnt_q + 1'b1;
            end
`else
            cnt_d = terminal ? '0 : cnt_q + 1'b1;
`endif
        end

        tc_d = en & terminal;
        for (int i = 0; i < CH; i++) begin
            pwm_d[i] = en & (cnt_q < duty_act_q[i*CNT_W +: CNT_W]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q      <= '0;
            per_act_q  <= DEF_P;
            per_sh_q   <= DEF_P;
            duty_act_q <= '0;
            duty_sh_q  <= '0;
            pend_q     <= 1'b0;
            tc_q       <= 1'b0;
            pwm_q      <= '0;
`ifdef PWM_CENTER_EN
            mode_act_q <= 1'b0;
            mode_sh_q  <= 1'b0;
            dir_down_q <= 1'b0;
`endif
        end else begin
            cnt_q      <= cnt_d;
            per_act_q  <= per_act_d;
            per_sh_q   <= per_sh_d;
            duty_act_q <= duty_act_d;
            duty_sh_q  <= duty_sh_d;
            pend_q     <= pend_d;
            tc_q       <= tc_d;
            pwm_q      <= pwm_d;
`ifdef PWM_CENTER_EN
            mode_act_q <= mode_act_d;
            mode_sh_q  <= mode_sh_d;
            dir_down_q <= dir_down_d;
`endif
        end
    end

    assign cfg_pend = pend_q;
    assign tc       = tc_q;
    assign pwm      = pwm_q;

endmodule

// File: tb/tb_pwm_div_multi.sv
// Testbench for pwm_div_multi with CNT_W=8, CH=2, DEF_PERIOD=4, edge-aligned build.
module tb_pwm_div_multi;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        cfg_wr = 1'b0;
    logic [7:0]  cfg_period = '0;
    logic [15:0] cfg_duty = '0;
    logic        cfg_center = 1'b0;
    logic        cfg_pend;
    logic        tc;
    logic [1:0]  pwm;

    int checks = 0;
    int errors = 0;

    pwm_div_multi #(.CNT_W(8), .CH(2), .DEF_PERIOD(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .cfg_wr     (cfg_wr),
        .cfg_period (cfg_period),
        .cfg_duty   (cfg_duty),
        .cfg_center (cfg_center),
        .cfg_pend   (cfg_pend),
        .tc         (tc),
        .pwm        (pwm)
    );

    always #5 clk = ~clk;

    typedef struct {
        string nm;
        int    p;
        int    d0;
        int    d1;
        int    e0;
        int    e1;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [7:0] p, input logic [7:0] d0, input logic [7:0] d1);
        cfg_period = p;
        cfg_duty   = {d1, d0};
        cfg_wr     = 1'b1;
        tick();
        cfg_wr     = 1'b0;
    endtask

    // Optionally syncs to a tc pulse. It then counts tc and pwm highs over
    // two full periods of p+1 cycles.
    task automatic measure(input string nm, input int p, input int e0, input int e1,
                           input bit sync);
        int k;
        int n_tc;
        int n0;
        int n1;
        if (sync) begin
            k = 0;
            while (tc !== 1'b1 && k < 600) begin
                tick();
                k++;
            end
            chk({nm, "_sync_tc"}, int'(tc === 1'b1), 1);
        end
        n_tc = 0;
        n0   = 0;
        n1   = 0;
        for (int c = 0; c < 2 * (p + 1); c++) begin
            tick();
            if (tc === 1'b1)     n_tc++;
            if (pwm[0] === 1'b1) n0++;
            if (pwm[1] === 1'b1) n1++;
        end
        chk({nm, "_tc_count"}, n_tc, 2);
        chk({nm, "_tc_last"}, int'(tc === 1'b1), 1);
        chk({nm, "_pwm0_high"}, n0, 2 * e0);
        chk({nm, "_pwm1_high"}, n1, 2 * e1);
    endtask

    initial begin
        vecs[0] = '{nm: "p4_d2_d4",    p: 4,   d0: 2,   d1: 4,   e0: 2,   e1: 4};
        vecs[1] = '{nm: "p9_d0_d255",  p: 9,   d0: 0,   d1: 255, e0: 0,   e1: 10};
        vecs[2] = '{nm: "p0_d1_d0",    p: 0,   d0: 1,   d1: 0,   e0: 1,   e1: 0};
        vecs[3] = '{nm: "p5_d5_d6",    p: 5,   d0: 5,   d1: 6,   e0: 5,   e1: 6};
        vecs[4] = '{nm: "p255_d128_1", p: 255, d0: 128, d1: 1,   e0: 128, e1: 1};
        vecs[5] = '{nm: "p9_d3_d7",    p: 9,   d0: 3,   d1: 7,   e0: 3,   e1: 7};

        // Reset state
        tick();
        tick();
        chk("reset_pwm", int'(pwm), 0);
        chk("reset_tc", int'(tc), 0);
        chk("reset_pend", int'(cfg_pend), 0);

        rst = 1'b1;
        en  = 1'b1;
        measure("default", 4, 0, 0, 1'b1);

        foreach (vecs[v]) begin
            en = 1'b0;
            tick();
            chk({vecs[v].nm, "_dis_pwm"}, int'(pwm), 0);
            chk({vecs[v].nm, "_dis_tc"}, int'(tc), 0);
            cfg(8'(vecs[v].p), 8'(vecs[v].d0), 8'(vecs[v].d1));
            chk({vecs[v].nm, "_pend_dis"}, int'(cfg_pend), 0);
            en = 1'b1;
            measure(vecs[v].nm, vecs[v].p, vecs[v].e0, vecs[v].e1, 1'b1);
        end

        // Running with P=9. After the measure, cnt=0 at the next edge.
        // Two writes before the boundary: the last one wins.
        for (int i = 0; i < 4; i++) tick();
        cfg(8'd6, 8'd1, 8'd7);
        chk("shadow_pend_w1", int'(cfg_pend), 1);
        cfg(8'd3, 8'd2, 8'd7);
        chk("shadow_pend_w2", int'(cfg_pend), 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("shadow_pend_hold", int'(cfg_pend), 1);
        end
        tick();
        chk("shadow_pend_clear", int'(cfg_pend), 0);
        chk("shadow_boundary_tc", int'(tc), 1);
        measure("shadow", 3, 2, 4, 1'b0);

        // Write on the terminal-count cycle: the values bypass to active.
        for (int i = 0; i < 3; i++) tick();
        cfg(8'd5, 8'd5, 8'd0);
        chk("bypass_pend", int'(cfg_pend), 0);
        chk("bypass_tc", int'(tc), 1);
        measure("bypass", 5, 5, 0, 1'b0);

        // Async reset mid-period with pending shadow data.
        tick();
        cfg(8'd2, 8'd1, 8'd1);
        chk("prerst_pend", int'(cfg_pend), 1);
        chk("prerst_pwm0", int'(pwm[0]), 1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_pwm", int'(pwm), 0);
        chk("async_rst_tc", int'(tc), 0);
        chk("async_rst_pend", int'(cfg_pend), 0);
        tick();
        rst = 1'b1;
        measure("post_reset", 4, 0, 0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
